// File: rtl/mac_bias_seq.sv
// Time-multiplexed spike-gated MAC with bias and output saturation.
// Optional build macro MAC_BIAS_RELU_EN clamps negative results to zero.

module mac_bias_lane #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic             pix,
  input  logic [WIDTH-1:0] w,
  output logic [ACC_W-1:0] val
);
  assign val = pix ? {{(ACC_W-WIDTH){w[WIDTH-1]}}, w} : '0;
endmodule

module mac_bias_seq #(
  parameter int WIDTH = 8,
  parameter int S     = 25,
  parameter int LANES = 5,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [S-1:0]         pixels,
  input  logic [S*WIDTH-1:0]   weights,
  input  logic [WIDTH-1:0]     bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     final_out,
  output logic                 busy
);
  localparam int BEATS = (S + LANES - 1) / LANES;
  localparam int PADS  = BEATS * LANES;
  localparam int WPAD  = PADS * WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (ACC_W < WIDTH + $clog2(S+1) + 1) begin : g_acc_chk
    $error("mac_bias_seq: ACC_W too narrow for WIDTH and S");
  end
  if (LANES < 1 || LANES > S) begin : g_lane_chk
    $error("mac_bias_seq: LANES must be in 1..S");
  end
  if (OUT_W > ACC_W || OUT_W < 2) begin : g_out_chk
    $error("mac_bias_seq: OUT_W must be in 2..ACC_W");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [PADS-1:0]    pix_q, pix_d;
  logic [WPAD-1:0]    w_q, w_d;
  logic [WIDTH-1:0]   bias_q, bias_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [OUT_W-1:0]   final_out_q, final_out_d;

  // Operands are zero-padded to a whole number of beats and shifted down one
  // beat per cycle, so the lanes always read the low slice and pad lanes add 0.
  logic [LANES-1:0][ACC_W-1:0] lane_val;
  logic [ACC_W-1:0]            beat_sum;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    mac_bias_lane #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_lane (
      .pix (pix_q[j]),
      .w   (w_q[j*WIDTH +: WIDTH]),
      .val (lane_val[j])
    );
  end

  always_comb begin
    beat_sum = '0;
    for (int j = 0; j < LANES; j++) beat_sum = beat_sum + lane_val[j];
  end

  logic signed [ACC_W-1:0] biased;
  logic [OUT_W-1:0]        sat;

  always_comb begin
    biased = $signed(acc_q) + $signed({{(ACC_W-WIDTH){bias_q[WIDTH-1]}}, bias_q});
    if (biased > MAX_V)      sat = MAX_V[OUT_W-1:0];
    else if (biased < MIN_V) sat = MIN_V[OUT_W-1:0];
    else                     sat = biased[OUT_W-1:0];
`ifdef MAC_BIAS_RELU_EN
    if (sat[OUT_W-1]) sat = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    pix_d       = pix_q;
    w_d         = w_q;
    bias_d      = bias_q;
    out_valid_d = out_valid_q;
    final_out_d = final_out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        pix_d   = PADS'(pixels);
        w_d     = WPAD'(weights);
        bias_d  = bias;
        acc_d   = '0;
        beat_d  = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_d  = acc_q + beat_sum;
        pix_d  = pix_q >> LANES;
        w_d    = w_q >> (LANES * WIDTH);
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(BEATS - 1)) state_d = BIAS;
      end
      BIAS: begin
        final_out_d = sat;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beat_q      <= '0;
      pix_q       <= '0;
      w_q         <= '0;
      bias_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      final_out_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      pix_q       <= pix_d;
      w_q         <= w_d;
      bias_q      <= bias_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      final_out_q <= final_out_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign final_out = final_out_q;
endmodule

// File: tb/tb_mac_bias_seq.sv
// Randomised bench for mac_bias_seq: default build plus an S=7, LANES=3 instance,
// checked against a direct dot-product/saturate reference.

module tb_mac_bias_seq;
  logic         clk = 0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [24:0]  pixels;
  logic [199:0] weights;
  logic [7:0]   bias, final_out;

  logic         in_valid7, in_ready7, out_valid7, out_ready7, busy7;
  logic [6:0]   pixels7;
  logic [55:0]  weights7;
  logic [7:0]   bias7, final_out7;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mac_bias_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pixels(pixels), .weights(weights), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .final_out(final_out), .busy(busy)
  );

  mac_bias_seq #(.S(7), .LANES(3)) dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7),
    .pixels(pixels7), .weights(weights7), .bias(bias7), .out_valid(out_valid7),
    .out_ready(out_ready7), .final_out(final_out7), .busy(busy7)
  );

  // Dot product of the selected weights, plus bias, clamped to the 8-bit range.
  function automatic logic [7:0] ref_mac(input int n, input logic [24:0] p,
                                         input logic [199:0] w, input logic [7:0] b);
    int s = 0;
    for (int i = 0; i < n; i++) if (p[i]) s += int'($signed(w[i*8 +: 8]));
    s += int'($signed(b));
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef MAC_BIAS_RELU_EN
    if (s < 0) s = 0;
`endif
    return 8'(s);
  endfunction

  function automatic logic [199:0] rand_w();
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[i*8 +: 8] = 8'($urandom);
    return w;
  endfunction

  function automatic logic [199:0] fill_w(input logic [7:0] v);
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[i*8 +: 8] = v;
    return w;
  endfunction

  task automatic do_txn(input logic [24:0] p, input logic [199:0] w, input logic [7:0] b,
                        output int lat, output int rdy_bad, output logic [7:0] res);
    pixels = p; weights = w; bias = b; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; pixels = 25'($urandom); weights = rand_w(); bias = 8'($urandom);
    lat = 1; rdy_bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0) rdy_bad++;
      @(posedge clk); #1; lat++;
    end
    if (in_ready !== 1'b0) rdy_bad++;
    res = final_out;
    @(posedge clk); #1;
  endtask

  task automatic do_txn7(input logic [6:0] p, input logic [55:0] w, input logic [7:0] b,
                         output int lat, output logic [7:0] res);
    pixels7 = p; weights7 = w; bias7 = b; in_valid7 = 1; out_ready7 = 1;
    @(posedge clk); #1;
    in_valid7 = 0; pixels7 = 7'($urandom); weights7 = 56'({$urandom, $urandom});
    lat = 1;
    while (!out_valid7 && lat < 40) begin @(posedge clk); #1; lat++; end
    res = final_out7;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks += 5;
    if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (final_out !== 8'h00) begin failures++; $display("FAIL reset_final_out got=%h exp=00", final_out); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (in_ready7 !== 1'b1)  begin failures++; $display("FAIL reset_in_ready7 got=%b exp=1", in_ready7); end
  endtask

  task automatic test_directed();
    logic [24:0]  p [5];
    logic [199:0] w [5];
    logic [7:0]   b [5];
    logic [7:0]   res, exp;
    int lat, rb;
    p[0] = '1; w[0] = fill_w(8'd3);    b[0] = 8'd5;
    p[1] = '1; w[1] = fill_w(8'd127);  b[1] = 8'd127;
    p[2] = '1; w[2] = fill_w(8'h80);   b[2] = 8'h80;
    p[3] = '0; w[3] = rand_w();        b[3] = 8'hF9;
    p[4] = 25'h1000000; w[4] = rand_w(); w[4][199:192] = 8'hEC; b[4] = 8'd4;
    for (int i = 0; i < 5; i++) begin
      do_txn(p[i], w[i], b[i], lat, rb, res);
      exp = ref_mac(25, p[i], w[i], b[i]);
      checks += 3;
      if (res !== exp) begin failures++; $display("FAIL directed%0d_result got=%h exp=%h", i, res, exp); end
      if (lat != 7)    begin failures++; $display("FAIL directed%0d_latency got=%0d exp=7", i, lat); end
      if (rb != 0)     begin failures++; $display("FAIL directed%0d_in_ready_low got=%0d bad cycles exp=0", i, rb); end
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL directed_idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_random();
    logic [24:0] p; logic [199:0] w; logic [7:0] b, res, exp;
    int lat, rb;
    for (int i = 0; i < 20; i++) begin
      p = 25'($urandom); w = rand_w(); b = 8'($urandom);
      if (i % 4 == 0) w = fill_w(8'($urandom_range(100, 127)));
      do_txn(p, w, b, lat, rb, res);
      exp = ref_mac(25, p, w, b);
      checks += 2;
      if (res !== exp) begin failures++; $display("FAIL random%0d_result got=%h exp=%h", i, res, exp); end
      if (lat != 7)    begin failures++; $display("FAIL random%0d_latency got=%0d exp=7", i, lat); end
    end
  endtask

  task automatic test_s7();
    logic [55:0] w; logic [199:0] wf; logic [7:0] b, res, exp; logic [6:0] p;
    int lat;
    for (int i = 0; i < 7; i++) w[i*8 +: 8] = 8'(i + 1);
    do_txn7('1, w, 8'd0, lat, res);
    wf = 200'(w);
    exp = ref_mac(7, 25'h7F, wf, 8'd0);
    checks += 2;
    if (res !== exp) begin failures++; $display("FAIL s7_ramp_result got=%h exp=%h", res, exp); end
    if (lat != 5)    begin failures++; $display("FAIL s7_latency got=%0d exp=5", lat); end
    for (int k = 0; k < 6; k++) begin
      p = 7'($urandom); w = 56'({$urandom, $urandom}); b = 8'($urandom);
      do_txn7(p, w, b, lat, res);
      wf = 200'(w);
      exp = ref_mac(7, 25'(p), wf, b);
      checks++;
      if (res !== exp) begin failures++; $display("FAIL s7_random%0d got=%h exp=%h", k, res, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [24:0] p1, p2; logic [199:0] w1, w2; logic [7:0] b1, b2, e1, e2;
    int lat;
    p1 = 25'($urandom); w1 = rand_w(); b1 = 8'($urandom);
    p2 = 25'($urandom); w2 = rand_w(); b2 = 8'($urandom);
    e1 = ref_mac(25, p1, w1, b1); e2 = ref_mac(25, p2, w2, b2);
    pixels = p1; weights = w1; bias = b1; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks += 2;
    if (lat != 7)     begin failures++; $display("FAIL bp_latency got=%0d exp=7", lat); end
    if (final_out !== e1) begin failures++; $display("FAIL bp_result got=%h exp=%h", final_out, e1); end
    pixels = p2; weights = w2; bias = b2; in_valid = 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold%0d_out_valid got=%b exp=1", c, out_valid); end
      if (final_out !== e1)   begin failures++; $display("FAIL bp_hold%0d_final_out got=%h exp=%h", c, final_out, e1); end
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_hold%0d_in_ready got=%b exp=0", c, in_ready); end
    end
    out_ready = 1;
    @(posedge clk); #1;
    checks += 3;
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    if (final_out !== e1)   begin failures++; $display("FAIL bp_release_final_out got=%h exp=%h", final_out, e1); end
    @(posedge clk); #1;
    in_valid = 0; lat = 1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept_next got=%b exp=0", in_ready); end
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks += 2;
    if (lat != 7)         begin failures++; $display("FAIL bp_next_latency got=%0d exp=7", lat); end
    if (final_out !== e2) begin failures++; $display("FAIL bp_next_result got=%h exp=%h", final_out, e2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] res, exp; int lat, rb;
    pixels = '1; weights = fill_w(8'd9); bias = 8'd1; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1;
    #1;
    checks += 4;
    if (in_ready !== 1'b1)   begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0)  begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    if (final_out !== 8'h00) begin failures++; $display("FAIL midrst_final_out got=%h exp=00", final_out); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    #2 rst = 0;
    @(posedge clk); #1;
    do_txn('1, fill_w(8'd2), 8'd0, lat, rb, res);
    exp = ref_mac(25, '1, fill_w(8'd2), 8'd0);
    checks += 2;
    if (res !== exp) begin failures++; $display("FAIL midrst_next_result got=%h exp=%h", res, exp); end
    if (lat != 7)    begin failures++; $display("FAIL midrst_next_latency got=%0d exp=7", lat); end
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; pixels = '0; weights = '0; bias = '0;
    in_valid7 = 0; out_ready7 = 1; pixels7 = '0; weights7 = '0; bias7 = '0;
    #1;
    test_reset();
    #11 rst = 0;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_s7();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
